// File: rtl/hamm_pkg.sv
// Shared Hamming(7,4) definitions used by the write-path encoder and the read-path decoder.
package hamm_pkg;

  localparam int P1_POS = 1;
  localparam int P2_POS = 2;
  localparam int P4_POS = 4;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  // Codeword position k lives at bit [k]; data occupies the non-power-of-two positions.
  function automatic logic [7:1] hamm_enc7(input logic [4:1] d, input logic parity_type);
    logic [7:1] c;
    c         = '0;
    c[3]      = d[1];
    c[5]      = d[2];
    c[6]      = d[3];
    c[7]      = d[4];
    c[P1_POS] = d[1] ^ d[2] ^ d[4] ^ parity_type;
    c[P2_POS] = d[1] ^ d[3] ^ d[4] ^ parity_type;
    c[P4_POS] = d[2] ^ d[3] ^ d[4] ^ parity_type;
    return c;
  endfunction

endpackage

// File: rtl/hamm_skid_buf.sv
// Two-entry valid/ready pipeline stage: one output register plus one skid entry.
module hamm_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_data
);

  logic         sk_valid;
  logic [W-1:0] sk_data;
  logic         accept;
  logic         out_free;

  // s_ready comes straight from a flop so m_ready never reaches the upstream side combinationally.
  assign s_ready  = !sk_valid;
  assign accept   = s_valid && s_ready;
  assign out_free = !m_valid || m_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid  <= 1'b0;
      m_data   <= '0;
      sk_valid <= 1'b0;
      sk_data  <= '0;
    end else if (out_free) begin
      if (sk_valid) begin
        m_data   <= sk_data;
        m_valid  <= 1'b1;
        sk_valid <= 1'b0;
      end else begin
        m_valid <= accept;
        if (accept) m_data <= s_data;
      end
    end else if (accept) begin
      sk_valid <= 1'b1;
      sk_data  <= s_data;
    end
  end

endmodule

// File: rtl/hamm_wr_encoder.sv
// Write-path ECC stage: nibble-wise Hamming(7,4) encode, one-shot bit-flip injection,
// skid-buffered output and a delivered-codeword counter.
module hamm_wr_encoder
  import hamm_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int CNT_W  = 16,
  localparam int NIB    = DATA_W / 4,
  localparam int CODE_W = NIB * 7,
  localparam int IDX_W  = $clog2(CODE_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              parity_type,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [CODE_W-1:0] m_code,
  input  logic              inject_arm,
  input  logic [IDX_W-1:0]  inject_bit,
  output logic              inject_pend,
  output logic [CNT_W-1:0]  enc_count
);

  logic [CODE_W-1:0] code;
  logic              accept;
  logic              deliver;
  logic              inj_en;

  assign accept  = s_valid && s_ready;
  assign deliver = m_valid && m_ready;
  assign inj_en  = inject_pend || inject_arm;

  // An out-of-range inject_bit matches no position, so nothing flips but the arm is still consumed.
  always_comb begin
    code = '0;
    for (int n = 0; n < NIB; n++) begin
      code[7*n +: 7] = hamm_enc7(s_data[4*n +: 4], parity_type);
    end
    for (int i = 0; i < CODE_W; i++) begin
      if (inj_en && (inject_bit == IDX_W'(i))) code[i] = ~code[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inject_pend <= 1'b0;
    end else if (accept && inj_en) begin
      inject_pend <= 1'b0;
    end else if (inject_arm) begin
      inject_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      enc_count <= '0;
    end else if (deliver) begin
      enc_count <= enc_count + CNT_W'(1);
    end
  end

  hamm_skid_buf #(.W(CODE_W)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (code),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_code)
  );

endmodule

// File: tb/tb_hamm_wr_encoder.sv
// Directed bench for hamm_wr_encoder with a queue scoreboard of expected codewords.
module tb_hamm_wr_encoder;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;
  localparam int NIB    = DATA_W / 4;
  localparam int CODE_W = NIB * 7;
  localparam int IDX_W  = $clog2(CODE_W);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              parity_type = 1'b0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [DATA_W-1:0] s_data = '0;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic [CODE_W-1:0] m_code;
  logic              inject_arm = 1'b0;
  logic [IDX_W-1:0]  inject_bit = '0;
  logic              inject_pend;
  logic [CNT_W-1:0]  enc_count;

  int n_checks = 0;
  int n_pass   = 0;

  logic [CODE_W-1:0] sb[$];
  logic              model_pend = 1'b0;
  logic [CNT_W-1:0]  model_cnt  = '0;

  always #5 clk = ~clk;

  hamm_wr_encoder dut (
    .clk         (clk),
    .rst         (rst),
    .parity_type (parity_type),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_code      (m_code),
    .inject_arm  (inject_arm),
    .inject_bit  (inject_bit),
    .inject_pend (inject_pend),
    .enc_count   (enc_count)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Reference codeword laid out as {d4,d3,d2,p4,d1,p2,p1} per nibble.
  function automatic logic [CODE_W-1:0] model_enc(input logic [DATA_W-1:0] w, input logic odd);
    logic [CODE_W-1:0] r;
    logic d1, d2, d3, d4;
    r = '0;
    for (int n = 0; n < NIB; n++) begin
      d1 = w[4*n]; d2 = w[4*n+1]; d3 = w[4*n+2]; d4 = w[4*n+3];
      r[7*n +: 7] = {d4, d3, d2, d2^d3^d4^odd, d1, d1^d3^d4^odd, d1^d2^d4^odd};
    end
    return r;
  endfunction

  function automatic logic [3:0] model_dec(input logic [6:0] c);
    logic [2:0] syn;
    logic [7:1] p;
    p = c;
    syn[0] = p[1] ^ p[3] ^ p[5] ^ p[7];
    syn[1] = p[2] ^ p[3] ^ p[6] ^ p[7];
    syn[2] = p[4] ^ p[5] ^ p[6] ^ p[7];
    if (syn != 3'd0) p[syn] = ~p[syn];
    return {p[7], p[6], p[5], p[3]};
  endfunction

  // Monitor on the falling edge: handshakes seen here complete on the next rising edge.
  always @(negedge clk) begin
    logic [CODE_W-1:0] e;
    if (rst) begin
      sb.delete();
      model_pend = 1'b0;
      model_cnt  = '0;
    end else begin
      chk("enc_count", enc_count, model_cnt);
      chk("inject_pend", inject_pend, model_pend);
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          $error("FAIL unexpected_delivery observed=%h expected=none", m_code);
        end else begin
          e = sb.pop_front();
          chk("m_code_sb", m_code, e);
        end
        model_cnt = model_cnt + 1'b1;
      end
      if (s_valid && s_ready) begin
        e = model_enc(s_data, parity_type);
        if (model_pend || inject_arm) begin
          if (int'(inject_bit) < CODE_W) e[inject_bit] = ~e[inject_bit];
          model_pend = 1'b0;
        end
        sb.push_back(e);
      end else if (inject_arm) begin
        model_pend = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DATA_W-1:0] w[8];
    logic [CODE_W-1:0] exp_code;
    logic [CODE_W-1:0] hold;
    int idx;
    logic will;

    // Reset state
    tick(); tick();
    chk("rst_s_ready", s_ready, 1'b1);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_code", m_code, '0);
    chk("rst_inject_pend", inject_pend, 1'b0);
    chk("rst_enc_count", enc_count, '0);
    rst = 1'b0;

    // 1: even parity single word
    m_ready = 1'b1; parity_type = 1'b0; s_data = 32'h0000000B; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    chk("t1_m_valid", m_valid, 1'b1);
    chk("t1_code0", m_code[6:0], 7'b1010101);
    chk("t1_others", m_code[CODE_W-1:7], '0);
    tick();
    chk("t1_valid_drop", m_valid, 1'b0);
    chk("t1_enc_count", enc_count, 16'd1);

    // 2: odd parity, same word
    parity_type = 1'b1; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    exp_code = {{(NIB-1){7'b0001011}}, 7'b1011110};
    chk("t2_code", m_code, exp_code);
    tick();
    chk("t2_enc_count", enc_count, 16'd2);

    // 3: backpressure fills both entries, then drain at full rate
    rst = 1'b1; tick(); rst = 1'b0;
    parity_type = 1'b0; m_ready = 1'b0;
    for (int i = 0; i < 8; i++) w[i] = $urandom;
    idx = 0; s_valid = 1'b1;
    repeat (5) begin
      s_data = w[idx]; will = s_ready;
      tick();
      if (will) idx++;
    end
    chk("t3_accepted", idx, 2);
    chk("t3_s_ready", s_ready, 1'b0);
    chk("t3_m_valid", m_valid, 1'b1);
    hold = m_code;
    tick();
    chk("t3_hold", m_code, hold);
    m_ready = 1'b1;
    repeat (8) begin
      s_valid = (idx < 8);
      if (idx < 8) s_data = w[idx];
      will = s_valid && s_ready;
      tick();
      if (will) idx++;
    end
    s_valid = 1'b0;
    chk("t3_all_accepted", idx, 8);
    chk("t3_enc_count", enc_count, 16'd8);
    chk("t3_sb_empty", sb.size(), 0);

    // 4: armed injection of bit 2, then a clean word
    inject_arm = 1'b1; inject_bit = 8'd2;
    tick();
    inject_arm = 1'b0;
    chk("t4_pend_set", inject_pend, 1'b1);
    s_data = 32'h0000000B; s_valid = 1'b1;
    tick();
    chk("t4_code0", m_code[6:0], 7'b1010001);
    chk("t4_pend_clr", inject_pend, 1'b0);
    chk("t4_decoded", model_dec(m_code[6:0]), 4'b1011);
    tick();
    s_valid = 1'b0;
    chk("t4_clean", m_code[6:0], 7'b1010101);
    tick();

    // 5: out-of-range index, armed in the same cycle as the accept
    inject_arm = 1'b1; inject_bit = 8'(CODE_W); s_valid = 1'b1;
    tick();
    inject_arm = 1'b0; s_valid = 1'b0;
    exp_code = {{(NIB-1){7'b0000000}}, 7'b1010101};
    chk("t5_code", m_code, exp_code);
    chk("t5_pend", inject_pend, 1'b0);
    tick();

    // 6: reset with two words buffered
    m_ready = 1'b0; s_valid = 1'b1; s_data = w[0];
    tick();
    s_data = w[1];
    tick();
    s_valid = 1'b0;
    chk("t6_full_s_ready", s_ready, 1'b0);
    rst = 1'b1;
    tick();
    chk("t6_m_valid", m_valid, 1'b0);
    chk("t6_s_ready", s_ready, 1'b1);
    chk("t6_enc_count", enc_count, '0);
    rst = 1'b0; m_ready = 1'b1;
    repeat (3) tick();
    chk("t6_no_delivery", enc_count, '0);
    chk("t6_idle", m_valid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
